cam_insert_engine: RTL and testbench

Lookup-or-insert initiator that sits in front of the `cam` block and drives its read/write/search port set. For each key request it searches the CAM:
- On a hit, it returns the stored index.
- On a miss, it allocates the next free entry, writes the key there and returns the new index.
- If the table is full, it reports full and writes nothing.

It gives upstream logic a single valid/ready request/response channel in place of raw CAM strobes.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_alloc_ctr.sv | 28 ++
 rtl/cam_insert_engine.sv | 154 +++++++++++++++
 tb/tb_cam_insert_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default sizing for the CAM lookup-or-insert engine.
// Optional readback check is enabled by defining CAM_INSERT_READBACK_EN.
package cam_pkg;

  // Default geometry: 32-bit keys, 32 entries.
  localparam int CAM_ARRAY_WIDTH_LOG2 = 5;
  localparam int CAM_ARRAY_SIZE_LOG2  = 5;
  localparam int DATA_W               = 2 ** CAM_ARRAY_WIDTH_LOG2;
  localparam int IDX_W                = CAM_ARRAY_SIZE_LOG2;

  // Engine states; READ and CHECK exist only with the readback feature.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_WAIT_S = 3'd2,
    ST_WRITE  = 3'd3,
`ifdef CAM_INSERT_READBACK_EN
    ST_READ   = 3'd4,
    ST_CHECK  = 3'd5,
`endif
    ST_RESP   = 3'd6
  } cam_ins_state_t;

endpackage

// File: rtl/cam_alloc_ctr.sv
// Linear entry allocator: next free index plus a saturating fill count.
module cam_alloc_ctr #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] alloc_ptr_o,
  output logic [IDX_W:0]   fill_count_o
);

  localparam logic [IDX_W:0]   FILL_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W-1:0] PTR_MAX  = {IDX_W{1'b1}};

  // Advance pointer and count on each allocation; both stop at the top.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset_i) begin
      alloc_ptr_o  <= '0;
      fill_count_o <= '0;
    end else if (inc_i) begin
      if (fill_count_o != FILL_MAX) fill_count_o <= fill_count_o + 1'b1;
      if (alloc_ptr_o != PTR_MAX)   alloc_ptr_o  <= alloc_ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/cam_insert_engine.sv
// Lookup-or-insert front end for a CAM: search, allocate-and-write on miss,
// report full when no entry is left. Define CAM_INSERT_READBACK_EN to add a
// read-after-write check that flags mismatches on rsp_err_o.
module cam_insert_engine
  import cam_pkg::*;
#(
  parameter  int ARRAY_WIDTH_LOG2 = CAM_ARRAY_WIDTH_LOG2,
  parameter  int ARRAY_SIZE_LOG2  = CAM_ARRAY_SIZE_LOG2,
  localparam int DW               = 2 ** ARRAY_WIDTH_LOG2,
  localparam int IW               = ARRAY_SIZE_LOG2
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_key_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [IW-1:0] rsp_index_o,
  output logic          rsp_hit_o,
  output logic          rsp_full_o,
  output logic          rsp_err_o,
  output logic [IW:0]   fill_count_o,
  output logic          cam_read_o,
  output logic [IW-1:0] cam_read_index_o,
  output logic          cam_write_o,
  output logic [IW-1:0] cam_write_index_o,
  output logic [DW-1:0] cam_write_data_o,
  output logic          cam_search_o,
  output logic [DW-1:0] cam_search_data_o,
  input  logic          cam_read_valid_i,
  input  logic [DW-1:0] cam_read_value_i,
  input  logic          cam_search_valid_i,
  input  logic [IW-1:0] cam_search_index_i
);

  localparam logic [IW:0] FILL_FULL = {1'b1, {IW{1'b0}}};

  cam_ins_state_t state_q, state_d;
  logic [DW-1:0]  key_q;
  logic [IW-1:0]  index_q;
  logic           hit_q;
  logic           full_q;
  logic [IW-1:0]  alloc_ptr;
  logic           table_full;

  assign table_full = (fill_count_o == FILL_FULL);

  cam_alloc_ctr #(.IDX_W(IW)) u_alloc (
    .clk          (clk),
    .reset_i      (reset_i),
    .inc_i        (state_q == ST_WRITE),
    .alloc_ptr_o  (alloc_ptr),
    .fill_count_o (fill_count_o)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = ST_SEARCH;
      ST_SEARCH: state_d = ST_WAIT_S;
      ST_WAIT_S: state_d = (cam_search_valid_i || table_full) ? ST_RESP : ST_WRITE;
`ifdef CAM_INSERT_READBACK_EN
      ST_WRITE:  state_d = ST_READ;
      ST_READ:   state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_RESP;
`else
      ST_WRITE:  state_d = ST_RESP;
`endif
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request key and response fields; cleared on acceptance, held through RESP.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      key_q   <= '0;
      index_q <= '0;
      hit_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid_i) begin
          key_q   <= req_key_i;
          index_q <= '0;
          hit_q   <= 1'b0;
          full_q  <= 1'b0;
        end
        ST_WAIT_S: begin
          if (cam_search_valid_i) begin
            hit_q   <= 1'b1;
            index_q <= cam_search_index_i;
          end else if (table_full) begin
            full_q  <= 1'b1;
            index_q <= '0;
          end
        end
        ST_WRITE: index_q <= alloc_ptr;
        default: ;
      endcase
    end
  end

  // Handshake and CAM strobes decode directly from the state.
  always_comb begin
    req_ready_o       = (state_q == ST_IDLE);
    rsp_valid_o       = (state_q == ST_RESP);
    rsp_index_o       = index_q;
    rsp_hit_o         = hit_q;
    rsp_full_o        = full_q;
    cam_search_o      = (state_q == ST_SEARCH);
    cam_search_data_o = cam_search_o ? key_q : '0;
    cam_write_o       = (state_q == ST_WRITE);
    cam_write_index_o = cam_write_o ? alloc_ptr : '0;
    cam_write_data_o  = cam_write_o ? key_q : '0;
  end

`ifdef CAM_INSERT_READBACK_EN
  logic err_q;

  // Compare the read-back entry against the key that was just written.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && req_valid_i) begin
      err_q <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      err_q <= !cam_read_valid_i || (cam_read_value_i != key_q);
    end
  end

  assign cam_read_o       = (state_q == ST_READ);
  assign cam_read_index_o = cam_read_o ? index_q : '0;
  assign rsp_err_o        = err_q;
`else
  // Read result port is not consumed without the readback check.
  logic unused_read;
  assign unused_read      = &{1'b0, cam_read_valid_i, cam_read_value_i};
  assign cam_read_o       = 1'b0;
  assign cam_read_index_o = '0;
  assign rsp_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_cam_insert_engine.sv
// Directed bench for cam_insert_engine with a behavioural CAM model.
// Define CAM_INSERT_READBACK_EN to exercise the readback path.
module tb_cam_insert_engine;

`ifdef CAM_INSERT_READBACK_EN
  localparam bit          READBACK = 1'b1;
  localparam int          INS_LAT  = 5;
  localparam logic [31:0] RB_XOR   = 32'h1;
`else
  localparam bit          READBACK = 1'b0;
  localparam int          INS_LAT  = 3;
  localparam logic [31:0] RB_XOR   = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_key_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [4:0]  rsp_index_o;
  logic        rsp_hit_o, rsp_full_o, rsp_err_o;
  logic [5:0]  fill_count_o;
  logic        cam_read_o, cam_write_o, cam_search_o;
  logic [4:0]  cam_read_index_o, cam_write_index_o;
  logic [31:0] cam_write_data_o, cam_search_data_o;
  logic        cam_read_valid_i, cam_search_valid_i;
  logic [31:0] cam_read_value_i;
  logic [4:0]  cam_search_index_i;

  always #5 clk = ~clk;

  cam_insert_engine dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_index_o(rsp_index_o),
    .rsp_hit_o(rsp_hit_o), .rsp_full_o(rsp_full_o), .rsp_err_o(rsp_err_o),
    .fill_count_o(fill_count_o),
    .cam_read_o(cam_read_o), .cam_read_index_o(cam_read_index_o),
    .cam_write_o(cam_write_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o),
    .cam_search_o(cam_search_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
  );

  // ---------------- CAM model and strobe monitor ----------------
  logic [31:0] mem [32];
  logic [31:0] vld;
  logic        s_hit;
  logic [4:0]  s_idx;
  int          wr_cnt = 0, rd_cnt = 0, multi_cnt = 0;
  logic [4:0]  last_wr_idx = '0;
  logic [31:0] last_wr_data = '0;

  always_comb begin
    s_hit = 1'b0;
    s_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vld[i] && mem[i] == cam_search_data_o) begin
        s_hit = 1'b1;
        s_idx = 5'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_i) begin
      vld                <= '0;
      cam_search_valid_i <= 1'b0;
      cam_search_index_i <= '0;
      cam_read_valid_i   <= 1'b0;
      cam_read_value_i   <= '0;
    end else begin
      if (cam_write_o) begin
        mem[cam_write_index_o] <= cam_write_data_o;
        vld[cam_write_index_o] <= 1'b1;
        wr_cnt       <= wr_cnt + 1;
        last_wr_idx  <= cam_write_index_o;
        last_wr_data <= cam_write_data_o;
      end
      if (cam_read_o) rd_cnt <= rd_cnt + 1;
      if (32'(cam_read_o) + 32'(cam_write_o) + 32'(cam_search_o) > 1) multi_cnt <= multi_cnt + 1;
      cam_search_valid_i <= cam_search_o && s_hit;
      cam_search_index_i <= cam_search_o ? s_idx : 5'd0;
      cam_read_valid_i   <= cam_read_o && vld[cam_read_index_o];
      cam_read_value_i   <= cam_read_o ? (mem[cam_read_index_o] ^ RB_XOR) : 32'd0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request: issue, time the response, check fields, optionally stall, release.
  task automatic do_req(input logic [31:0] key, input logic exp_hit, input logic exp_full,
                        input logic [4:0] exp_idx, input logic [5:0] exp_fill, input int hold);
    int cyc;
    int w0;
    int exp_lat;
    logic exp_err;
    exp_lat = (exp_hit || exp_full) ? 2 : INS_LAT;
    exp_err = READBACK && !exp_hit && !exp_full;
    w0 = wr_cnt;
    check("req_ready before request", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_key_i   = key;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 0;
    while (!rsp_valid_o && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("response latency", 64'(cyc), 64'(exp_lat));
    check("rsp_hit", 64'(rsp_hit_o), 64'(exp_hit));
    check("rsp_full", 64'(rsp_full_o), 64'(exp_full));
    check("rsp_index", 64'(rsp_index_o), 64'(exp_idx));
    check("rsp_err", 64'(rsp_err_o), 64'(exp_err));
    check("fill_count", 64'(fill_count_o), 64'(exp_fill));
    check("write strobes", 64'(wr_cnt - w0), (exp_hit || exp_full) ? 64'd0 : 64'd1);
    if (!exp_hit && !exp_full) begin
      check("write index", 64'(last_wr_idx), 64'(exp_idx));
      check("write data", 64'(last_wr_data), 64'(key));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("stall rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("stall rsp_index", 64'(rsp_index_o), 64'(exp_idx));
      check("stall rsp_hit", 64'(rsp_hit_o), 64'(exp_hit));
      check("stall req_ready", 64'(req_ready_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_valid after release", 64'(rsp_valid_o), 64'd0);
    check("req_ready after release", 64'(req_ready_o), 64'd1);
  endtask

  typedef struct {
    logic [31:0] key;
    logic        hit;
    logic        full;
    logic [4:0]  idx;
    logic [5:0]  fill;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0005, 1'b0, 1'b0, 5'd0, 6'd1};
    vecs[1] = '{32'h0000_0005, 1'b1, 1'b0, 5'd0, 6'd1};
    vecs[2] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 5'd1, 6'd2};
    vecs[3] = '{32'h0000_0005, 1'b1, 1'b0, 5'd0, 6'd2};
    vecs[4] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 5'd1, 6'd2};
    vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 5'd2, 6'd3};

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    check("reset req_ready", 64'(req_ready_o), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset fill_count", 64'(fill_count_o), 64'd0);
    check("reset strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);

    // Table-driven insert / hit sequence.
    for (int v = 0; v < 6; v++)
      do_req(vecs[v].key, vecs[v].hit, vecs[v].full, vecs[v].idx, vecs[v].fill, 0);

    // Backpressure: response held for 5 cycles.
    do_req(32'h0000_ABCD, 1'b0, 1'b0, 5'd3, 6'd4, 5);

    // Fresh table, fill to capacity.
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    for (int k = 1; k <= 32; k++)
      do_req(32'(k), 1'b0, 1'b0, 5'(k - 1), 6'(k), 0);
    do_req(32'd33, 1'b0, 1'b1, 5'd0, 6'd32, 0);
    do_req(32'd17, 1'b1, 1'b0, 5'd16, 6'd32, 0);

    // Reset during WRITE aborts the request.
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    req_valid_i = 1'b1;
    req_key_i   = 32'h0000_0007;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("write strobe before abort", 64'(cam_write_o), 64'd1);
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    check("abort strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
    check("abort fill_count", 64'(fill_count_o), 64'd0);
    check("abort req_ready", 64'(req_ready_o), 64'd1);
    repeat (4) @(negedge clk);
    check("abort no response", 64'(rsp_valid_o), 64'd0);
    do_req(32'h0000_0007, 1'b0, 1'b0, 5'd0, 6'd1, 0);

    check("read strobe count", 64'(rd_cnt), READBACK ? 64'(wr_cnt) : 64'd0);
    check("overlapping strobes", 64'(multi_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
